// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encodings and PC arithmetic constants.
package pc_seq_defs;

    localparam int          PC_W   = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decode, ALU, data memory and the PC sequencer.
// BRANCH_NE exists only when PC_SEQ_BNE_EN is defined.
interface pc_sequencer_if;

    logic        BRANCH;
    logic        JUMP;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic        BUSYWAIT;
`ifdef PC_SEQ_BNE_EN
    logic        BRANCH_NE;
`endif
    logic [31:0] PC;
    logic        FLOW_TAKEN;
    logic        INSTR_VALID;
    logic        STALLED;
    logic [7:0]  REDIRECT_COUNT;

`ifdef PC_SEQ_BNE_EN
    modport master (
        output BRANCH, JUMP, ZERO, OFFSET, BUSYWAIT, BRANCH_NE,
        input  PC, FLOW_TAKEN, INSTR_VALID, STALLED, REDIRECT_COUNT
    );

    modport slave (
        input  BRANCH, JUMP, ZERO, OFFSET, BUSYWAIT, BRANCH_NE,
        output PC, FLOW_TAKEN, INSTR_VALID, STALLED, REDIRECT_COUNT
    );
`else
    modport master (
        output BRANCH, JUMP, ZERO, OFFSET, BUSYWAIT,
        input  PC, FLOW_TAKEN, INSTR_VALID, STALLED, REDIRECT_COUNT
    );

    modport slave (
        input  BRANCH, JUMP, ZERO, OFFSET, BUSYWAIT,
        output PC, FLOW_TAKEN, INSTR_VALID, STALLED, REDIRECT_COUNT
    );
`endif

endinterface

// File: rtl/pc_target_adder.sv
// Pure combinational next-PC candidates: PC+4 and PC+4+(sign-extended word offset << 2).
import pc_seq_defs::*;

module pc_target_adder (
    input  logic [31:0] pc,
    input  logic [7:0]  offset,
    output logic [31:0] pc_plus4,
    output logic [31:0] target
);

    logic [31:0] byte_offset_s;

    // Word offset to byte offset; arithmetic wraps modulo 2^32 by design.
    assign byte_offset_s = {{22{offset[7]}}, offset, 2'b00};
    assign pc_plus4      = pc + PC_INC;
    assign target        = pc_plus4 + byte_offset_s;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and BOOT/RUN/STALL sequencer for the 8-bit single-cycle CPU.
// Optional macro PC_SEQ_BNE_EN adds a branch-if-not-equal redirect condition.
import pc_seq_defs::*;

module pc_sequencer #(
    parameter int unsigned BOOT_CYCLES = 1,
    parameter logic [31:0] PC_RESET    = 32'd0
) (
    input  logic             CLK,
    input  logic             RESET,
    pc_sequencer_if.slave    bus
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 32'd1);

    seq_state_e  state_r;
    seq_state_e  next_state_s;
    logic [3:0]  boot_cnt_r;
    logic [3:0]  next_boot_cnt_s;
    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic [7:0]  redirect_cnt_r;
    logic [7:0]  next_redirect_cnt_s;
    logic        instr_valid_r;
    logic        stalled_r;
    logic        flow_raw_s;
    logic        flow_taken_s;
    logic        commit_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;

    pc_target_adder u_target_adder (
        .pc       (pc_r),
        .offset   (bus.OFFSET),
        .pc_plus4 (pc_plus4_s),
        .target   (target_s)
    );

`ifdef PC_SEQ_BNE_EN
    assign flow_raw_s = bus.JUMP | (bus.BRANCH & bus.ZERO) | (bus.BRANCH_NE & ~bus.ZERO);
`else
    assign flow_raw_s = bus.JUMP | (bus.BRANCH & bus.ZERO);
`endif

    // Next-state, commit decision and next register values.
    always_comb begin
        next_state_s        = state_r;
        next_boot_cnt_s     = boot_cnt_r;
        flow_taken_s        = 1'b0;
        commit_s            = 1'b0;
        case (state_r)
            S_BOOT: begin
                next_boot_cnt_s = boot_cnt_r + 4'd1;
                if (boot_cnt_r >= BOOT_LAST) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_BOOT;
                end
            end
            S_RUN, S_STALL: begin
                flow_taken_s = flow_raw_s;
                if (bus.BUSYWAIT) begin
                    next_state_s = S_STALL;
                end else begin
                    commit_s     = 1'b1;
                    next_state_s = S_RUN;
                end
            end
            default: begin
                next_state_s = S_BOOT;
            end
        endcase

        if (commit_s) begin
            next_pc_s = flow_taken_s ? target_s : pc_plus4_s;
        end else begin
            next_pc_s = pc_r;
        end

        if (commit_s && flow_taken_s && (redirect_cnt_r != 8'hFF)) begin
            next_redirect_cnt_s = redirect_cnt_r + 8'd1;
        end else begin
            next_redirect_cnt_s = redirect_cnt_r;
        end
    end

    // State, PC, counters and registered status flags; reset discards any pending update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r        <= S_BOOT;
            boot_cnt_r     <= 4'd0;
            pc_r           <= PC_RESET;
            redirect_cnt_r <= 8'd0;
            instr_valid_r  <= 1'b0;
            stalled_r      <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            boot_cnt_r     <= next_boot_cnt_s;
            pc_r           <= next_pc_s;
            redirect_cnt_r <= next_redirect_cnt_s;
            instr_valid_r  <= (next_state_s == S_RUN);
            stalled_r      <= (next_state_s == S_STALL);
        end
    end

    assign bus.PC             = pc_r;
    assign bus.FLOW_TAKEN     = flow_taken_s;
    assign bus.INSTR_VALID    = instr_valid_r;
    assign bus.STALLED        = stalled_r;
    assign bus.REDIRECT_COUNT = redirect_cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (BOOT_CYCLES=1, PC_RESET=0).
`timescale 1ns/1ps

module tb_pc_sequencer;

    logic clk;
    logic rst;
    int   checks_cnt;
    int   errors_cnt;

    pc_sequencer_if ifc ();

    pc_sequencer #(
        .BOOT_CYCLES (1),
        .PC_RESET    (32'd0)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic iv,
                             input logic st, input logic [7:0] cnt);
        check_val({tag, "_pc"},  ifc.PC, pc);
        check_val({tag, "_iv"},  32'(ifc.INSTR_VALID), 32'(iv));
        check_val({tag, "_st"},  32'(ifc.STALLED), 32'(st));
        check_val({tag, "_cnt"}, 32'(ifc.REDIRECT_COUNT), 32'(cnt));
    endtask

    // Advance one posedge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic jp, input logic zr,
                         input logic [7:0] off, input logic bw);
        ifc.BRANCH   = br;
        ifc.JUMP     = jp;
        ifc.ZERO     = zr;
        ifc.OFFSET   = off;
        ifc.BUSYWAIT = bw;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
`ifdef PC_SEQ_BNE_EN
        ifc.BRANCH_NE = 1'b0;
`endif
        // Reset with JUMP high: FLOW_TAKEN must stay forced low.
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h05, 1'b0);
        step();
        step();
        check_all("rst", 32'd0, 1'b0, 1'b0, 8'd0);
        check_val("rst_ft", 32'(ifc.FLOW_TAKEN), 32'd0);

        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        step();
        check_all("boot_exit", 32'd0, 1'b1, 1'b0, 8'd0);
        step();
        check_all("seq4", 32'd4, 1'b1, 1'b0, 8'd0);
        step();
        check_all("seq8", 32'd8, 1'b1, 1'b0, 8'd0);

        // Taken branch backwards: 8+4-8 = 4.
        drive(1'b1, 1'b0, 1'b1, 8'hFE, 1'b0);
        #1 check_val("beq_ft", 32'(ifc.FLOW_TAKEN), 32'd1);
        step();
        check_all("beq_taken", 32'd4, 1'b1, 1'b0, 8'd1);

        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check_all("seq8b", 32'd8, 1'b1, 1'b0, 8'd1);

        drive(1'b1, 1'b0, 1'b0, 8'hFE, 1'b0);
        #1 check_val("bnt_ft", 32'(ifc.FLOW_TAKEN), 32'd0);
        step();
        check_all("beq_not", 32'd12, 1'b1, 1'b0, 8'd1);

        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check_all("seq16", 32'd16, 1'b1, 1'b0, 8'd1);

        // Stall 3 edges with a pending jump, then commit 16+4+8 = 28.
        drive(1'b0, 1'b1, 1'b0, 8'h02, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("stall", 32'd16, 1'b0, 1'b1, 8'd1);
            check_val("stall_ft", 32'(ifc.FLOW_TAKEN), 32'd1);
        end
        ifc.BUSYWAIT = 1'b0;
        step();
        check_all("stall_rel", 32'd28, 1'b1, 1'b0, 8'd2);

        // Jump back to 0xFFFFFFF8 (28+4-40), then wrap 0xFFFFFFF8+4+4 = 0.
        drive(1'b0, 1'b1, 1'b0, 8'hF6, 1'b0);
        step();
        check_all("jneg", 32'hFFFFFFF8, 1'b1, 1'b0, 8'd3);
        drive(1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
        step();
        check_all("jwrap", 32'h00000000, 1'b1, 1'b0, 8'd4);

        // JUMP and BRANCH together, ZERO=0: still taken, 0+4-8 = 0xFFFFFFFC.
        drive(1'b1, 1'b1, 1'b0, 8'hFE, 1'b0);
        step();
        check_all("jb_both", 32'hFFFFFFFC, 1'b1, 1'b0, 8'd5);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check_all("seqwrap", 32'd0, 1'b1, 1'b0, 8'd5);

        // OFFSET=-1 jump keeps PC at 0; count 5 + 250 = 255, then stays saturated.
        drive(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 250; i++) step();
        check_all("sat_reach", 32'd0, 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 50; i++) step();
        check_all("sat_hold", 32'd0, 1'b1, 1'b0, 8'hFF);

        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check_all("pre_stall", 32'd4, 1'b1, 1'b0, 8'hFF);

        // Reset during a stall with a pending jump discards the jump.
        drive(1'b0, 1'b1, 1'b0, 8'h02, 1'b1);
        step();
        check_all("stall2", 32'd4, 1'b0, 1'b1, 8'hFF);
        rst = 1'b1;
        step();
        check_all("rst_stall", 32'd0, 1'b0, 1'b0, 8'd0);
        check_val("rst_stall_ft", 32'(ifc.FLOW_TAKEN), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check_all("reboot", 32'd0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) step();
        check_all("seq20", 32'd20, 1'b1, 1'b0, 8'd0);

`ifdef PC_SEQ_BNE_EN
        // bne taken: 20+4+12 = 36; then bne with ZERO=1 falls through to 40.
        drive(1'b0, 1'b0, 1'b0, 8'h03, 1'b0);
        ifc.BRANCH_NE = 1'b1;
        step();
        check_all("bne_taken", 32'd36, 1'b1, 1'b0, 8'd1);
        ifc.ZERO = 1'b1;
        step();
        check_all("bne_not", 32'd40, 1'b1, 1'b0, 8'd1);
        // BRANCH and BRANCH_NE together always redirect: 40+4+12 = 56.
        ifc.BRANCH = 1'b1;
        ifc.ZERO   = 1'b0;
        step();
        check_all("bne_both", 32'd56, 1'b1, 1'b0, 8'd2);
        ifc.BRANCH_NE = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction flow for the 8-bit single-cycle CPU.
- Each cycle it picks sequential (PC+4) or redirected (PC+4+offset*4) next-PC from decode/ALU flags.
- Holds PC while data memory asserts BUSYWAIT, and inserts a boot wait after reset for instruction-memory latency.
- Sits between the control unit, the ALU ZERO flag, the data-memory BUSYWAIT and the instruction memory address port.

Parameters:
- BOOT_CYCLES, 1, cycles PC is held at 0 after reset release before the first update (range 1-15).
- PC_RESET, 32'd0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- BRANCH  input  1  beq-class instruction in decode.
- JUMP  input  1  j-class instruction in decode.
- ZERO  input  1  ALU zero flag for the current instruction.
- OFFSET  input  8  signed word offset from instruction [23:16].
- BUSYWAIT  input  1  data memory busy; PC must hold.
- PC  output  32  current instruction address (registered).
- FLOW_TAKEN  output  1  combinational: redirect selected for the current instruction.
- INSTR_VALID  output  1  high in RUN state only.
- STALLED  output  1  high in STALL state only.
- REDIRECT_COUNT  output  8  saturating count of committed redirects.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high, sampled at the posedge, and has priority over all other inputs including BUSYWAIT.
- Reset values: PC=PC_RESET, state=BOOT, boot counter=0, REDIRECT_COUNT=0, INSTR_VALID=0, STALLED=0, FLOW_TAKEN=0.
- States: BOOT, RUN, STALL. State register encoding is 2 bits.
- BOOT:
  - PC held; FLOW_TAKEN forced 0.
  - Counter increments each cycle.
  - After BOOT_CYCLES posedges, go to RUN. No PC update on the exit edge.
- RUN:
  - FLOW_TAKEN = JUMP | (BRANCH & ZERO).
  - At posedge with BUSYWAIT=1: PC held, go to STALL.
  - At posedge with BUSYWAIT=0: PC <= FLOW_TAKEN ? target : PC+4; stay in RUN.
- STALL:
  - PC held. FLOW_TAKEN still reflects live inputs.
  - At posedge with BUSYWAIT=0: commit the update exactly as in RUN using the inputs present at that edge, then go to RUN.
  - At posedge with BUSYWAIT=1: remain in STALL.
- Target = PC + 4 + (sign_extend32(OFFSET) << 2). All arithmetic is 32-bit modulo 2^32, so wrap-around is legal: PC=32'hFFFFFFFC, no redirect -> 0.
- JUMP and BRANCH both high: treated as taken, same target.
- REDIRECT_COUNT:
  - +1 on each committed update with FLOW_TAKEN=1.
  - Holds at 8'hFF.
  - Does not count while held in STALL; counts once on the committing edge.
- Latency: PC changes one posedge after a non-stalled RUN cycle. No speculative update.
- Reset mid-STALL or mid-BOOT: the next posedge returns to the BOOT reset values and discards any pending update.

Optional Feature:
- Macro: PC_SEQ_BNE_EN.
- When defined:
  - Adds input BRANCH_NE (1 bit).
  - FLOW_TAKEN = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO).
  - BRANCH and BRANCH_NE both high: the redirect is always taken.
- When undefined: the port is absent and the equation is the base one.

Decomposition:
- Shared package/header pc_seq_defs: state encodings (S_BOOT=2'd0, S_RUN=2'd1, S_STALL=2'd2), PC width 32, PC increment 4.
- One natural sub-module, pc_target_adder: a pure combinational block producing PC+4 and the redirect target from PC and OFFSET.
- Sequencer FSM, PC register and counter live in pc_sequencer.

Test Plan:
- Reset/boot: RESET high 2 cycles, then low, BOOT_CYCLES=1, no flags -> PC=0 for one cycle after release, then 4, 8, 12; INSTR_VALID rises with the first RUN cycle.
- Redirects:
  - PC=8, BRANCH=1, ZERO=1, OFFSET=8'hFE -> PC=4 next edge, REDIRECT_COUNT=1.
  - BRANCH=1, ZERO=0 -> PC=12.
- Stall: PC=16, BUSYWAIT high 3 cycles with JUMP=1, OFFSET=8'h02 -> PC stays 16, STALLED=1 for 3 cycles; on the release edge PC=28, REDIRECT_COUNT +1 only.
- Wrap and saturation:
  - PC=32'hFFFFFFF8, JUMP=1, OFFSET=8'h01 -> PC=32'h00000000.
  - 300 consecutive taken jumps -> REDIRECT_COUNT=8'hFF.
- Reset in STALL: RESET asserted while BUSYWAIT=1 and JUMP=1 -> next edge PC=0, state BOOT, count 0, no redirect committed.
- PC_SEQ_BNE_EN: BRANCH_NE=1, ZERO=0, OFFSET=8'h03, PC=20 -> PC=36; with ZERO=1 -> PC=24.
